param_sequence_detector: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed 4-bit Moore detector. The match pattern, its length (1..MAX_LEN) and overlap mode are runtime-programmable. Input is valid-qualified, the match output is a registered one-cycle pulse, and a saturating match counter is included. The block sits between the serial stimulus source and the checker/scoreboard in the sequence-detection datapath.

---
 rtl/param_sequence_detector.sv | 128 ++++++++++++
 tb/tb_param_sequence_detector.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sequence_detector.sv
// Runtime-programmable serial pattern detector with valid-qualified input,
// registered one-cycle match pulse and a saturating match counter.
module param_sequence_detector #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               cfg_load,
  input  logic [MAX_LEN-1:0]                 cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]       cfg_len,
  input  logic                               cfg_overlap,
  output logic                               cfg_err,
  input  logic                               in_valid,
  input  logic                               sequence_in,
  input  logic                               clear_count,
  output logic                               detector_out,
  output logic [CNT_W-1:0]                   match_count,
  output logic                               count_sat
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(4'b1011);
  localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4);
  localparam logic [LEN_W-1:0]   MAX_FILL = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic               cfg_ok;
  logic               accept;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W:0]     fill_inc;
  logic               pat_eq;
  logic               match;

  // Config acceptance, bit acceptance and match evaluation on the shifted history
  always_comb begin
    cfg_ok     = cfg_load && (cfg_len != '0) && (cfg_len <= MAX_FILL);
    accept     = in_valid && !cfg_ok;
    hist_shift = {hist_q[MAX_LEN-2:0], sequence_in};
    fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
    pat_eq     = 1'b1;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W+1)'(i) < {1'b0, len_q} && hist_shift[i] != pat_q[i]) begin
        pat_eq = 1'b0;
      end
    end
    match = accept && (fill_inc >= {1'b0, len_q}) && pat_eq;
  end

  // Next-state for config, history/fill, pulses and counter
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = match;
    err_d  = cfg_load && !cfg_ok;
    cnt_d  = cnt_q;
    sat_d  = sat_q;

    if (cfg_ok) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      if (match && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != MAX_FILL) begin
        fill_d = fill_inc[LEN_W-1:0];
      end
    end

    if (clear_count) begin
      cnt_d = match ? CNT_W'(1) : '0;
      sat_d = 1'b0;
    end else if (match && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) begin
        sat_d = 1'b1;
      end
    end
  end

  // State registers with default config on reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q  <= DEF_PAT;
      len_q  <= DEF_LEN;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign detector_out = det_q;
  assign cfg_err      = err_q;
  assign match_count  = cnt_q;
  assign count_sat    = sat_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Bench for param_sequence_detector: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_param_sequence_detector;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               sequence_in;
  logic               clear_count;

  logic               err_a, det_a, sat_a;
  logic [15:0]        cnt_a;
  logic               err_b, det_b, sat_b;
  logic [1:0]         cnt_b;

  param_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(err_a),
    .in_valid(in_valid), .sequence_in(sequence_in), .clear_count(clear_count),
    .detector_out(det_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  param_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_small (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(err_b),
    .in_valid(in_valid), .sequence_in(sequence_in), .clear_count(clear_count),
    .detector_out(det_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the accepted bits since the last restart, oldest first
  bit          m_q[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ovl;
  bit          e_det, e_err;
  int          m_cnt_a, m_cnt_b;
  bit          m_sat_a, m_sat_b;

  task automatic model_reset();
    m_q.delete();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
    e_det = 1'b0; e_err = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
  endtask

  task automatic model_step(input bit ld, input logic [7:0] pat, input int len,
                            input bit ovl, input bit v, input bit b, input bit clr);
    bit m;
    m = 1'b0;
    e_err = 1'b0;
    if (ld && len >= 1 && len <= MAX_LEN) begin
      m_pat = pat; m_len = len; m_ovl = ovl;
      m_q.delete();
    end else begin
      if (ld) e_err = 1'b1;
      if (v) begin
        m_q.push_back(b);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        if (m_q.size() >= m_len) begin
          m = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_q[m_q.size()-1-k] != m_pat[k]) m = 1'b0;
        end
        if (m && !m_ovl) m_q.delete();
      end
    end
    e_det = m;
    if (clr) begin
      m_cnt_a = m ? 1 : 0; m_cnt_b = m ? 1 : 0;
      m_sat_a = 1'b0; m_sat_b = 1'b0;
    end else if (m) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_a == 65535) m_sat_a = 1'b1;
      if (m_cnt_b < 3) m_cnt_b++;
      if (m_cnt_b == 3) m_sat_b = 1'b1;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and land 1ns after the edge
  task automatic drive(input bit ld, input logic [7:0] pat, input int len,
                       input bit ovl, input bit v, input bit b, input bit clr);
    cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    in_valid = v; sequence_in = b; clear_count = clr;
    @(posedge clock);
    model_step(ld, pat, len, ovl, v, b, clr);
    #1;
  endtask

  task automatic send(input bit v, input bit b);
    drive(1'b0, 8'h00, 0, 1'b0, v, b, 1'b0);
  endtask

  task automatic do_reset();
    cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    in_valid = 0; sequence_in = 0; clear_count = 0;
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({det_a, err_a, cnt_a, sat_a} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_a got det=%0b err=%0b cnt=%0d sat=%0b exp all 0", det_a, err_a, cnt_a, sat_a);
    end
    n_checks++;
    if ({det_b, err_b, cnt_b, sat_b} !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_b got det=%0b err=%0b cnt=%0d sat=%0b exp all 0", det_b, err_b, cnt_b, sat_b);
    end
  endtask

  task automatic test_default_stream();
    int bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    int ep[7]   = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(1'b1, bits[i][0]);
      n_checks++;
      if (det_a !== ep[i][0]) begin
        n_errors++;
        $display("FAIL default_det[%0d] got %0b exp %0b", i, det_a, ep[i][0]);
      end
    end
    n_checks++;
    if (cnt_a !== 16'd2) begin
      n_errors++;
      $display("FAIL default_count got %0d exp 2", cnt_a);
    end
  endtask

  task automatic test_overlap();
    int ep0[4] = '{0, 1, 0, 1};
    int ep1[4] = '{0, 1, 1, 1};
    int c0;
    do_reset();
    drive(1'b1, 8'b11, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1);
      n_checks++;
      if (det_a !== ep0[i][0]) begin
        n_errors++;
        $display("FAIL nonovl_det[%0d] got %0b exp %0b", i, det_a, ep0[i][0]);
      end
    end
    n_checks++;
    if (cnt_a !== 16'd2) begin
      n_errors++;
      $display("FAIL nonovl_count got %0d exp 2", cnt_a);
    end
    c0 = 2;
    drive(1'b1, 8'b11, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1);
      n_checks++;
      if (det_a !== ep1[i][0]) begin
        n_errors++;
        $display("FAIL ovl_det[%0d] got %0b exp %0b", i, det_a, ep1[i][0]);
      end
    end
    n_checks++;
    if (int'(cnt_a) - c0 !== 3) begin
      n_errors++;
      $display("FAIL ovl_count_delta got %0d exp 3", int'(cnt_a) - c0);
    end
  endtask

  task automatic test_valid_gap();
    int pulses;
    pulses = 0;
    do_reset();
    send(1'b1, 1'b1); pulses += int'(det_a);
    send(1'b1, 1'b0); pulses += int'(det_a);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b1);
      n_checks++;
      if (det_a !== 1'b0) begin
        n_errors++;
        $display("FAIL gap_det[%0d] got %0b exp 0", i, det_a);
      end
    end
    send(1'b1, 1'b1); pulses += int'(det_a);
    send(1'b1, 1'b1);
    n_checks++;
    if (det_a !== 1'b1 || pulses != 0) begin
      n_errors++;
      $display("FAIL gap_final got det=%0b early_pulses=%0d exp det=1 early_pulses=0", det_a, pulses);
    end
  endtask

  task automatic test_cfg_err();
    int ep[3] = '{0, 0, 1};
    do_reset();
    drive(1'b1, 8'hFF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_a !== 1'b1) begin
      n_errors++;
      $display("FAIL cfg_err_len0 got %0b exp 1", err_a);
    end
    // rejected load carrying the first stream bit, which must still count
    drive(1'b1, 8'hFF, MAX_LEN + 1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (err_a !== 1'b1 || det_a !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_err_lenmax got err=%0b det=%0b exp err=1 det=0", err_a, det_a);
    end
    send(1'b1, 1'b0);
    n_checks++;
    if (err_a !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_err_clear got %0b exp 0", err_a);
    end
    for (int i = 1; i < 3; i++) begin
      send(1'b1, 1'b1);
      n_checks++;
      if (det_a !== ep[i][0]) begin
        n_errors++;
        $display("FAIL cfg_err_stream[%0d] got %0b exp %0b", i, det_a, ep[i][0]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 8'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1);
    n_checks++;
    if (cnt_b !== 2'd3 || sat_b !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_hold got cnt=%0d sat=%0b exp cnt=3 sat=1", cnt_b, sat_b);
    end
    n_checks++;
    if (cnt_a !== 16'd4 || sat_a !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_wide got cnt=%0d sat=%0b exp cnt=4 sat=0", cnt_a, sat_a);
    end
    drive(1'b0, 8'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (cnt_b !== 2'd0 || sat_b !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_alone got cnt=%0d sat=%0b exp cnt=0 sat=0", cnt_b, sat_b);
    end
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1);
    drive(1'b0, 8'h0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (cnt_b !== 2'd1 || sat_b !== 1'b0 || det_b !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_with_match got cnt=%0d sat=%0b det=%0b exp cnt=1 sat=0 det=1", cnt_b, sat_b, det_b);
    end
  endtask

  task automatic test_mid_reset();
    int ep[4] = '{0, 0, 0, 1};
    do_reset();
    drive(1'b1, 8'b0110, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    reset = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (det_a !== 1'b0 || cnt_a !== 16'd0) begin
      n_errors++;
      $display("FAIL async_reset got det=%0b cnt=%0d exp det=0 cnt=0", det_a, cnt_a);
    end
    @(negedge clock);
    reset = 1'b1;
    send(1'b1, 1'b0);
    n_checks++;
    if (det_a !== 1'b0) begin
      n_errors++;
      $display("FAIL lost_partial got %0b exp 0", det_a);
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, i == 1 ? 1'b0 : 1'b1);
      n_checks++;
      if (det_a !== ep[i][0]) begin
        n_errors++;
        $display("FAIL restored_default[%0d] got %0b exp %0b", i, det_a, ep[i][0]);
      end
    end
  endtask

  task automatic test_random();
    bit ld, ovl, v, b, clr;
    int len;
    logic [7:0] pat;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ld  = ($urandom % 24) == 0;
      len = ($urandom % 8 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
      pat = 8'($urandom);
      ovl = 1'($urandom);
      v   = ($urandom % 4) != 0;
      b   = 1'($urandom);
      clr = ($urandom % 80) == 0;
      drive(ld, pat, len, ovl, v, b, clr);
      n_checks++;
      if (det_a !== e_det || det_b !== e_det || err_a !== e_err) begin
        n_errors++;
        $display("FAIL rand_pulse[%0d] got det=%0b/%0b err=%0b exp det=%0b err=%0b",
                 n, det_a, det_b, err_a, e_det, e_err);
      end
      n_checks++;
      if (cnt_a !== 16'(m_cnt_a) || sat_a !== m_sat_a || cnt_b !== 2'(m_cnt_b) || sat_b !== m_sat_b) begin
        n_errors++;
        $display("FAIL rand_count[%0d] got %0d/%0b %0d/%0b exp %0d/%0b %0d/%0b",
                 n, cnt_a, sat_a, cnt_b, sat_b, m_cnt_a, m_sat_a, m_cnt_b, m_sat_b);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_default_stream();
    test_overlap();
    test_valid_gap();
    test_cfg_err();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
